pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5: register-specifier width.
REQ-002 SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  in  1: asynchronous, active-low; state clears immediately when low.
REQ-005 SHALL have port fd_rs1, fd_rs2  in  REG_W: source registers of the instruction in D.
REQ-006 SHALL have port dx_rd  in  REG_W: destination register of the instruction in X.
REQ-007 SHALL have port dx_is_load  in  1: the instruction in X is a load.
REQ-008 SHALL have port dx_is_multdiv  in  1: the instruction in X is a mult or div.
REQ-009 SHALL have port branch_taken  in  1: the instruction in X redirects the PC.
REQ-010 SHALL have port multdiv_ready  in  1: one-cycle result-valid pulse from the multdiv unit.
REQ-011 SHALL have ports pc_en, fd_en, dx_en, xm_en, mw_en  out  1 each: write enables of PC and the pipeline latches.
REQ-012 SHALL have ports fd_flush, dx_flush, xm_flush  out  1 each: load a NOP (all-zero IR) into that latch.
REQ-013 SHALL have port md_start  out  1: one-cycle start pulse to the multdiv unit.
REQ-014 SHALL have port md_busy  out  1: high while in MD_WAIT.
REQ-015 SHALL have port stall_count  out  CNT_W: count of cycles with pc_en low.

Function
REQ-016 SHALL implement FSM states RUN and MD_WAIT; outputs are combinational from state and inputs.
REQ-017 SHALL hold xm_en and mw_en at 1 in every state, so W and M always drain.
REQ-018 In RUN with dx_is_multdiv=1: md_start=1; pc_en=fd_en=dx_en=0; xm_flush=1; next state MD_WAIT.
REQ-019 In MD_WAIT with multdiv_ready=0: pc_en=fd_en=dx_en=0; xm_flush=1; md_start=0; md_busy=1; stay in MD_WAIT.
REQ-020 In MD_WAIT with multdiv_ready=1: all enables 1; no flush; next state RUN, so the multdiv result advances to M in that same edge.
REQ-021 In RUN, SHALL ignore multdiv_ready.
REQ-022 In RUN with branch_taken=1 and dx_is_multdiv=0: all enables 1; fd_flush=1 and dx_flush=1, squashing the two younger instructions.
REQ-023 Load-use hazard: dx_is_load=1, dx_rd!=0, and dx_rd equals fd_rs1 or fd_rs2.
REQ-024 In RUN with a load-use hazard and no branch or multdiv: pc_en=fd_en=0; dx_en=1; dx_flush=1, giving exactly one bubble.
REQ-025 Priority, highest first: multdiv start, branch_taken, load-use, normal.
REQ-026 Normal operation: all enables 1; all flushes 0; md_start=0.
REQ-027 stall_count SHALL increment on each edge where pc_en=0 and saturate at all-ones; it never wraps.
REQ-028 A register match against x0 SHALL never stall.

Reset
REQ-029 While reset=0: state=RUN, stall_count=0, md_start=0, md_busy=0.
REQ-030 Reset asserted in MD_WAIT SHALL return the FSM to RUN asynchronously.
REQ-031 A multdiv_ready arriving after reset SHALL be ignored.
REQ-032 After reset release, the first edge SHALL evaluate RUN rules.

Structure
REQ-033 Package pipe_ctrl_pkg SHALL hold the state enum {RUN, MD_WAIT}, REG_W and CNT_W.
REQ-034 SHALL contain one sub-module, hazard_detect: a combinational load-use comparator whose output is the hazard bit.
REQ-035 The state register and the counter SHALL be the only sequential elements.

Verification
REQ-036 Load-use: dx_is_load=1, dx_rd=5, fd_rs2=5 -> one cycle with pc_en=fd_en=0 and dx_flush=1; stall_count=1.
REQ-037 Load to x0: dx_is_load=1, dx_rd=0, fd_rs1=0 -> no stall; all enables 1.
REQ-038 Multdiv: dx_is_multdiv=1, multdiv_ready pulses 17 cycles later -> md_start high in cycle 0 only; pc_en low for 17 cycles; release and RUN on the ready cycle; stall_count=17.
REQ-039 Branch and load-use together: branch_taken=1 with a load-use hazard -> fd_flush=dx_flush=1, pc_en=1, no stall.
REQ-040 Reset mid-operation: reset low during MD_WAIT cycle 4 -> md_busy=0 immediately; state RUN after release; a later stray multdiv_ready has no effect.
REQ-041 Saturation: CNT_W=4 with a 20-cycle multdiv -> stall_count holds at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default widths for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: flags a D-stage source that needs a load still in X.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             dx_is_load,
    input  logic [REG_W-1:0] dx_rd,
    input  logic [REG_W-1:0] fd_rs1,
    input  logic [REG_W-1:0] fd_rs2,
    output logic             hazard
);

    logic rd_nonzero;
    logic rs_match;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    always_comb begin
        rd_nonzero = (dx_rd != '0);
        rs_match   = (dx_rd == fd_rs1) || (dx_rd == fd_rs2);
        hazard     = dx_is_load && rd_nonzero && rs_match;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: multdiv wait FSM, branch squash, load-use bubble, stall counter.
module pipe_ctrl #(
    parameter int REG_W = pipe_ctrl_pkg::REG_W,
    parameter int CNT_W = pipe_ctrl_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] fd_rs1,
    input  logic [REG_W-1:0] fd_rs2,
    input  logic [REG_W-1:0] dx_rd,
    input  logic             dx_is_load,
    input  logic             dx_is_multdiv,
    input  logic             branch_taken,
    input  logic             multdiv_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             xm_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             xm_flush,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count
);

    import pipe_ctrl_pkg::*;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             load_use;

    hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard_detect (
        .dx_is_load(dx_is_load),
        .dx_rd     (dx_rd),
        .fd_rs1    (fd_rs1),
        .fd_rs2    (fd_rs2),
        .hazard    (load_use)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        dx_en    = 1'b1;
        xm_en    = 1'b1;
        mw_en    = 1'b1;
        fd_flush = 1'b0;
        dx_flush = 1'b0;
        xm_flush = 1'b0;
        md_start = 1'b0;
        md_busy  = 1'b0;

        case (state_q)
            RUN: begin
                if (dx_is_multdiv) begin
                    // start pulse is masked during reset so the unit never launches
                    md_start = reset;
                    pc_en    = 1'b0;
                    fd_en    = 1'b0;
                    dx_en    = 1'b0;
                    xm_flush = 1'b1;
                    state_d  = MD_WAIT;
                end else if (branch_taken) begin
                    fd_flush = 1'b1;
                    dx_flush = 1'b1;
                end else if (load_use) begin
                    pc_en    = 1'b0;
                    fd_en    = 1'b0;
                    dx_flush = 1'b1;
                end
            end
            MD_WAIT: begin
                md_busy = 1'b1;
                // on the ready cycle everything advances so the result lands in M
                if (multdiv_ready) begin
                    state_d = RUN;
                end else begin
                    pc_en    = 1'b0;
                    fd_en    = 1'b0;
                    dx_en    = 1'b0;
                    xm_flush = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        stall_d = stall_q;
        if (!pc_en && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, branch priority, multdiv wait, reset, saturation.
module tb_pipe_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  fd_rs1, fd_rs2, dx_rd;
    logic        dx_is_load, dx_is_multdiv, branch_taken, multdiv_ready;

    logic        pc_en, fd_en, dx_en, xm_en, mw_en;
    logic        fd_flush, dx_flush, xm_flush, md_start, md_busy;
    logic [15:0] stall_count;

    logic        s_pc_en, s_fd_en, s_dx_en, s_xm_en, s_mw_en;
    logic        s_fd_flush, s_dx_flush, s_xm_flush, s_md_start, s_md_busy;
    logic [3:0]  s_stall_count;

    logic [9:0]  ctl, s_ctl;
    int          errors;
    int          checks;

    // {pc,fd,dx,xm,mw enables | fd,dx,xm flushes | md_start, md_busy}
    localparam logic [9:0] C_NORMAL  = 10'b11111_000_00;
    localparam logic [9:0] C_LDUSE   = 10'b00111_010_00;
    localparam logic [9:0] C_BRANCH  = 10'b11111_110_00;
    localparam logic [9:0] C_MDSTART = 10'b00011_001_10;
    localparam logic [9:0] C_MDWAIT  = 10'b00011_001_01;
    localparam logic [9:0] C_MDREL   = 10'b11111_000_01;
    localparam logic [9:0] C_RSTMD   = 10'b00011_001_00;

    pipe_ctrl #(.REG_W(5), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .dx_rd(dx_rd),
        .dx_is_load(dx_is_load), .dx_is_multdiv(dx_is_multdiv),
        .branch_taken(branch_taken), .multdiv_ready(multdiv_ready),
        .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush),
        .md_start(md_start), .md_busy(md_busy), .stall_count(stall_count)
    );

    pipe_ctrl #(.REG_W(5), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset),
        .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .dx_rd(dx_rd),
        .dx_is_load(dx_is_load), .dx_is_multdiv(dx_is_multdiv),
        .branch_taken(branch_taken), .multdiv_ready(multdiv_ready),
        .pc_en(s_pc_en), .fd_en(s_fd_en), .dx_en(s_dx_en), .xm_en(s_xm_en), .mw_en(s_mw_en),
        .fd_flush(s_fd_flush), .dx_flush(s_dx_flush), .xm_flush(s_xm_flush),
        .md_start(s_md_start), .md_busy(s_md_busy), .stall_count(s_stall_count)
    );

    assign ctl   = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush, md_start, md_busy};
    assign s_ctl = {s_pc_en, s_fd_en, s_dx_en, s_xm_en, s_mw_en, s_fd_flush, s_dx_flush, s_xm_flush,
                    s_md_start, s_md_busy};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic ld, input logic md, input logic br, input logic rdy,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        @(negedge clk);
        dx_is_load    = ld;
        dx_is_multdiv = md;
        branch_taken  = br;
        multdiv_ready = rdy;
        dx_rd         = rd;
        fd_rs1        = rs1;
        fd_rs2        = rs2;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++; $display("FAIL reset_ctl: got %b want %b", ctl, C_NORMAL);
        end
        checks++;
        if (stall_count !== 16'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", stall_count);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (ctl !== C_RSTMD) begin
            errors++; $display("FAIL reset_no_start: got %b want %b", ctl, C_RSTMD);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        reset = 1'b1;
    endtask

    task automatic test_normal();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 5'd4, 5'd6);
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++; $display("FAIL normal_load_nomatch: got %b want %b", ctl, C_NORMAL);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd7);
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++; $display("FAIL normal_alu_match: got %b want %b", ctl, C_NORMAL);
        end
    endtask

    task automatic test_load_use();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd1, 5'd5);
        checks++;
        if (ctl !== C_LDUSE) begin
            errors++; $display("FAIL lduse_rs2: got %b want %b", ctl, C_LDUSE);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd5);
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++; $display("FAIL lduse_one_bubble: got %b want %b", ctl, C_NORMAL);
        end
        checks++;
        if (stall_count !== 16'd1) begin
            errors++; $display("FAIL lduse_cnt: got %0d want 1", stall_count);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 5'd31, 5'd2);
        checks++;
        if (ctl !== C_LDUSE) begin
            errors++; $display("FAIL lduse_rs1: got %b want %b", ctl, C_LDUSE);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++; $display("FAIL load_x0: got %b want %b", ctl, C_NORMAL);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (stall_count !== 16'd2) begin
            errors++; $display("FAIL load_x0_cnt: got %0d want 2", stall_count);
        end
    endtask

    task automatic test_branch();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (ctl !== C_BRANCH) begin
            errors++; $display("FAIL branch_plain: got %b want %b", ctl, C_BRANCH);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 5'd9, 5'd0);
        checks++;
        if (ctl !== C_BRANCH) begin
            errors++; $display("FAIL branch_over_lduse: got %b want %b", ctl, C_BRANCH);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++; $display("FAIL run_ignores_ready: got %b want %b", ctl, C_NORMAL);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (ctl !== C_NORMAL || stall_count !== 16'd2) begin
            errors++; $display("FAIL branch_no_stall: got %b cnt %0d want %b cnt 2", ctl, stall_count, C_NORMAL);
        end
    endtask

    task automatic test_multdiv();
        int bad;
        // branch and hazard also asserted: multdiv start must win
        drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 5'd4, 5'd0);
        checks++;
        if (ctl !== C_MDSTART) begin
            errors++; $display("FAIL md_start: got %b want %b", ctl, C_MDSTART);
        end
        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
            checks++;
            if (ctl !== C_MDWAIT) begin
                errors++; $display("FAIL md_wait_c%0d: got %b want %b", i, ctl, C_MDWAIT);
            end
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        checks++;
        if (ctl !== C_MDREL) begin
            errors++; $display("FAIL md_release: got %b want %b", ctl, C_MDREL);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++; $display("FAIL md_back_run: got %b want %b", ctl, C_NORMAL);
        end
        checks++;
        if (stall_count !== 16'd19) begin
            errors++; $display("FAIL md_cnt: got %0d want 19", stall_count);
        end
    endtask

    task automatic test_reset_mid_md();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 1; i <= 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (md_busy !== 1'b1) begin
            errors++; $display("FAIL rst_md_busy_before: got %b want 1", md_busy);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (md_busy !== 1'b0 || md_start !== 1'b0 || stall_count !== 16'd0) begin
            errors++; $display("FAIL rst_async: got busy %b start %b cnt %0d want 0 0 0",
                               md_busy, md_start, stall_count);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        reset = 1'b1;
        #1;
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++; $display("FAIL rst_release_run: got %b want %b", ctl, C_NORMAL);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++; $display("FAIL rst_stray_ready: got %b want %b", ctl, C_NORMAL);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (ctl !== C_NORMAL || stall_count !== 16'd0) begin
            errors++; $display("FAIL rst_after_stray: got %b cnt %0d want %b cnt 0", ctl, stall_count, C_NORMAL);
        end
    endtask

    task automatic test_saturation();
        checks++;
        if (s_stall_count !== 4'd0) begin
            errors++; $display("FAIL sat_start: got %0d want 0", s_stall_count);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 1; i <= 19; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
            if (i == 15) begin
                checks++;
                if (s_stall_count !== 4'd15) begin
                    errors++; $display("FAIL sat_reach15: got %0d want 15", s_stall_count);
                end
            end
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        checks++;
        if (s_ctl !== C_MDREL) begin
            errors++; $display("FAIL sat_release: got %b want %b", s_ctl, C_MDREL);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 5'd6, 5'd0);
        checks++;
        if (stall_count !== 16'd20 || s_stall_count !== 4'd15) begin
            errors++; $display("FAIL sat_hold: got %0d/%0d want 20/15", stall_count, s_stall_count);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (stall_count !== 16'd21 || s_stall_count !== 4'd15) begin
            errors++; $display("FAIL sat_no_wrap: got %0d/%0d want 21/15", stall_count, s_stall_count);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b0;
        dx_is_load    = 1'b0;
        dx_is_multdiv = 1'b0;
        branch_taken  = 1'b0;
        multdiv_ready = 1'b0;
        dx_rd         = '0;
        fd_rs1        = '0;
        fd_rs2        = '0;
        test_reset();
        test_normal();
        test_load_use();
        test_branch();
        test_multdiv();
        test_reset_mid_md();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
